// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the single-port memory bus, bundled for mem_arbiter.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_BITS-1:0]  addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  done0, done1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, mem_addr, mem_wdata, mem_wen
  );

  // Requesters and memory model side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, mem_addr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Two-input grant selection: a lone request wins outright, a tie goes to prio_i.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic    req0_i,
  input  logic    req1_i,
  input  req_id_t prio_i,
  output logic    vld_o,
  output req_id_t id_o
);

  // Resolve the winner combinationally from the current requests.
  always_comb begin
    vld_o = req0_i | req1_i;
    id_o  = REQ0;
    if (req0_i && req1_i) begin
      id_o = prio_i;
    end else if (req1_i) begin
      id_o = REQ1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port registered memory.
// Each access walks IDLE -> ISSUE -> CAPTURE -> DONE (4 cycles, reads and writes alike).
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise requester 0 always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_t                state_q, state_d;
  req_id_t               winner_q, winner_d;
  logic                  we_q, we_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  pick_vld;
  req_id_t               pick_id;
  req_id_t               prio;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t prio_q, prio_d;

  // Priority pointer: after each grant, the other requester wins the next tie.
  always_comb begin
    prio_d = prio_q;
    if (state_q == IDLE && pick_vld) begin
      prio_d = (pick_id == REQ0) ? REQ1 : REQ0;
    end
  end

  // Pointer register, starts favouring requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= REQ0;
    else     prio_q <= prio_d;
  end

  assign prio = prio_q;
`else
  assign prio = REQ0;
`endif

  arb_pick u_pick (
    .req0_i (bus.req0),
    .req1_i (bus.req1),
    .prio_i (prio),
    .vld_o  (pick_vld),
    .id_o   (pick_id)
  );

  // Next-state and registered-output logic; done and mem_wen are single-cycle by default.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    we_d        = we_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d  = ISSUE;
          winner_d = pick_id;
          gnt0_d   = (pick_id == REQ0);
          gnt1_d   = (pick_id == REQ1);
          if (pick_id == REQ1) begin
            we_d        = bus.we1;
            mem_wen_d   = bus.we1;
            mem_addr_d  = bus.addr1;
            mem_wdata_d = bus.wdata1;
          end else begin
            we_d        = bus.we0;
            mem_wen_d   = bus.we0;
            mem_addr_d  = bus.addr0;
            mem_wdata_d = bus.wdata0;
          end
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!we_q) rdata_d = bus.mem_rdata;
        done0_d = (winner_q == REQ0);
        done1_d = (winner_q == REQ1);
        state_d = DONE;
      end
      DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      winner_q    <= REQ0;
      we_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      we_q        <= we_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed accesses, a timeline model of the expected
// outputs, and a behavioural single-port registered memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(8), .ADDR_BITS(5)) bus ();

  mem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory: write on mem_wen, registered read of the sampled address.
  logic [7:0] tb_mem [32];
  bit         tb_mem_init = 1'b0;
  always @(posedge clk) begin
    if (!tb_mem_init) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= 8'(i * 3 + 1);
      tb_mem_init <= 1'b1;
    end else begin
      if (bus.mem_wen) tb_mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= tb_mem[bus.mem_addr];
    end
  end

  int wen_cnt = 0;
  always @(negedge clk) if (bus.mem_wen === 1'b1) wen_cnt++;

  // Timeline model: an access accepted at edge 0 owns gnt for edges 0..2,
  // touches memory at edge 1, delivers done/rdata after edge 2, frees at edge 3.
  logic [7:0] mdl_mem [32];
  bit         mdl_init = 1'b0;
  bit         act = 1'b0;
  int         age = 0;
  bit         m_id, m_we, last_id = 1'b1;
  logic [4:0] m_addr;
  logic [7:0] m_wd, m_rd;
  logic       e_gnt0 = 0, e_gnt1 = 0, e_done0 = 0, e_done1 = 0, e_wen = 0;
  logic [4:0] e_maddr = 0;
  logic [7:0] e_mwd = 0, e_rdata = 0;

  always @(posedge clk or posedge rst) begin
    bit id;
    if (!mdl_init) begin
      for (int i = 0; i < 32; i++) mdl_mem[i] = 8'(i * 3 + 1);
      mdl_init = 1'b1;
    end
    if (rst) begin
      act = 0; last_id = 1'b1;
      e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_wen = 0;
      e_maddr = 0; e_mwd = 0; e_rdata = 0;
    end else begin
      e_done0 = 0; e_done1 = 0; e_wen = 0;
      if (act) begin
        age++;
        if (age == 1) begin
          if (m_we) mdl_mem[m_addr] = m_wd;
          else      m_rd = mdl_mem[m_addr];
        end else if (age == 2) begin
          if (!m_we) e_rdata = m_rd;
          if (m_id) e_done1 = 1; else e_done0 = 1;
        end else begin
          act = 0; e_gnt0 = 0; e_gnt1 = 0;
        end
      end else if (bus.req0 || bus.req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        id = (bus.req0 && bus.req1) ? !last_id : !bus.req0;
`else
        id = !bus.req0;
`endif
        act = 1; age = 0; m_id = id; last_id = id;
        m_we   = id ? bus.we1    : bus.we0;
        m_addr = id ? bus.addr1  : bus.addr0;
        m_wd   = id ? bus.wdata1 : bus.wdata0;
        e_gnt0 = !id; e_gnt1 = id;
        e_wen = m_we; e_maddr = m_addr; e_mwd = m_wd;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_gnt0", bus.gnt0, e_gnt0);
    chk("cyc_gnt1", bus.gnt1, e_gnt1);
    chk("cyc_done0", bus.done0, e_done0);
    chk("cyc_done1", bus.done1, e_done1);
    chk("cyc_mem_wen", bus.mem_wen, e_wen);
    chk("cyc_mem_addr", bus.mem_addr, e_maddr);
    chk("cyc_mem_wdata", bus.mem_wdata, e_mwd);
    chk("cyc_rdata", bus.rdata, e_rdata);
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // One access from an idle arbiter; lat counts negedges from request to done.
  task automatic access(input bit id, input bit we, input logic [4:0] a,
                        input logic [7:0] d, output int lat, output logic [7:0] rd);
    if (id) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
    else    begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
    lat = 0;
    rd  = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if ((id && bus.done1) || (!id && bus.done0)) begin
        lat = k;
        rd  = bus.rdata;
        break;
      end
    end
    step();
    if (id) bus.req1 = 0; else bus.req0 = 0;
  endtask

  initial begin
    int         lat, n, cnt, w0;
    logic [7:0] rd;
    int         ids [4];
    int         stamps [4];
    int         got;

    // Reset values.
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_done0", bus.done0, 0);
    chk("rst_mem_wen", bus.mem_wen, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    step();

    // Write A5 to addr 5, then read it back.
    w0 = wen_cnt;
    access(0, 1, 5'd5, 8'hA5, lat, rd);
    chk("wr5_latency", lat, 4);
    chk("wr5_wen_cycles", wen_cnt - w0, 1);
    chk("wr5_mem", tb_mem[5], 8'hA5);
    access(0, 0, 5'd5, 8'h00, lat, rd);
    chk("rd5_latency", lat, 4);
    chk("rd5_rdata", rd, 8'hA5);

    // Write holds rdata; a following read of an untouched address updates it.
    w0 = wen_cnt;
    access(1, 1, 5'd9, 8'h11, lat, rd);
    chk("wr9_latency", lat, 4);
    chk("wr9_rdata_held", rd, 8'hA5);
    chk("wr9_wen_cycles", wen_cnt - w0, 1);
    chk("wr9_mem", tb_mem[9], 8'h11);
    access(0, 0, 5'd12, 8'h00, lat, rd);
    chk("rd12_rdata", rd, 8'h25);

    // Both requesters held high continuously.
    reset_dut();
    bus.req0 = 1; bus.addr0 = 5'd1;
    bus.req1 = 1; bus.addr1 = 5'd2;
    n = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if ((bus.done0 || bus.done1) && n < 4) begin
        ids[n]    = bus.done1 ? 1 : 0;
        stamps[n] = k;
        n++;
      end
    end
    chk("tie_done_count", n, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("tie_order", ids[i], i % 2);
`else
      chk("tie_order", ids[i], 0);
`endif
      if (i > 0) chk("tie_spacing", stamps[i] - stamps[i-1], 4);
    end
    step();
    clear_inputs();
    repeat (6) step();

    // Single read from requester 1 while requester 0 keeps requesting.
    reset_dut();
    bus.req0 = 1; bus.addr0 = 5'd0;
    step();
    bus.req1 = 1; bus.addr1 = 5'd3;
    got = 0;
    rd  = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.done1) begin
        got = 1;
        rd  = bus.rdata;
        break;
      end
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("starve_done1_seen", got, 1);
    chk("starve_rdata", rd, 8'h0A);
`else
    chk("fixed_req1_waits", got, 0);
`endif
    step();
    clear_inputs();
    repeat (6) step();

    // Requester 1 drops its request during CAPTURE.
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5'd4;
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.gnt1) n++;
      if (n == 2) break;
    end
    chk("drop_reach_capture", n, 2);
    bus.req1 = 0;
    @(negedge clk);
    chk("drop_done1", bus.done1, 1);
    chk("drop_rdata", bus.rdata, 8'h0D);
    @(negedge clk);
    chk("drop_gnt1_clear", bus.gnt1, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done1) cnt++;
    end
    chk("drop_no_extra_done", cnt, 0);
    step();

    // Asynchronous reset while a write to addr 7 is in ISSUE.
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5'd7; bus.wdata0 = 8'h3C;
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.gnt0 && bus.mem_wen) begin
        n = 1;
        break;
      end
    end
    chk("arst_reach_issue", n, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt0", bus.gnt0, 0);
    chk("arst_done0", bus.done0, 0);
    chk("arst_mem_wen", bus.mem_wen, 0);
    chk("arst_mem_addr", bus.mem_addr, 0);
    chk("arst_mem_wdata", bus.mem_wdata, 0);
    chk("arst_rdata", bus.rdata, 0);
    clear_inputs();
    step();
    rst = 1'b0;
    chk("arst_mem7_kept", tb_mem[7], 8'h16);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done0) cnt++;
    end
    chk("arst_no_done", cnt, 0);
    step();
    access(0, 0, 5'd7, 8'h00, lat, rd);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_rdata", rd, 8'h16);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width.
REQ-002 Parameter ADDR_BITS, default 5, memory address width (32 words).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read.
REQ-007 addr0, addr1  input  ADDR_BITS each  requested word address.
REQ-008 wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-009 gnt0, gnt1  output  1 each  requester owns the memory port.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  DATA_WIDTH  read result, valid while done0/done1 high.
REQ-012 mem_addr, mem_wdata, mem_wen  output  ADDR_BITS/DATA_WIDTH/1  drive single-port registered memory (write on wen, else registered read).
REQ-013 mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after address is sampled.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, CAPTURE, DONE; any other encoding SHALL return to IDLE next cycle.
REQ-015 IDLE: if req0|req1 at an edge, winner latched, gnt<winner>, mem_addr, mem_wdata, mem_wen registered from winner's inputs; go to ISSUE.
REQ-016 ISSUE: memory samples port at this edge; mem_wen SHALL clear at the same edge; go to CAPTURE.
REQ-017 CAPTURE: at edge, rdata SHALL load mem_rdata for reads (hold previous value for writes); done<winner> set; go to DONE.
REQ-018 DONE: done pulse lasts exactly this cycle; at edge gnt and done clear; go to IDLE.
REQ-019 Latency: request sampled at edge N -> done high during cycle N+3; throughput one access per 4 cycles.
REQ-020 Exactly one of gnt0/gnt1 SHALL be high from ISSUE through DONE; none in IDLE; done only with matching gnt.
REQ-021 Requester SHALL hold req/we/addr/wdata stable until its done; arbiter samples them only in IDLE.
REQ-022 req held high through DONE is treated as a new request in the following IDLE cycle.
REQ-023 req dropping mid-access SHALL NOT abort the access; it completes and pulses done.
REQ-024 Simultaneous req0 and req1: arbitration per REQ-029/030; loser waits, no request is lost.
REQ-025 Reads and writes take identical cycle counts; mem_wen high for exactly one cycle per write.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, gnt0/1=0, done0/1=0, mem_wen=0, mem_addr=0, mem_wdata=0, rdata=0, priority pointer to requester 0.
REQ-027 rst mid-access SHALL abort it with no done pulse; a write in ISSUE is suppressed by mem_wen clearing immediately.
REQ-028 First arbitration after rst release SHALL use normal rules.

Configuration
REQ-029 With MEM_ARB_ROUND_ROBIN_EN defined: on tie, requester not granted most recently wins; pointer updates on each grant.
REQ-030 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 always wins ties; no pointer register.

Structure
REQ-031 Package mem_arb_pkg SHALL hold state enum (IDLE, ISSUE, CAPTURE, DONE), default DATA_WIDTH/ADDR_BITS constants, requester-ID type.
REQ-032 Sub-module arb_pick (2-input grant selection, fixed or round-robin) is natural; FSM and port muxing stay in mem_arbiter.

Verification
REQ-033 Write then read: req0 we0=1 addr0=5 wdata0=8'hA5 -> mem_wen one cycle, done0 at N+3; then req0 read addr 5 -> rdata=8'hA5 with done0.
REQ-034 Tie with RR: req0 and req1 held high continuously -> grants alternate 0,1,0,1, each done 4 cycles apart; without macro -> req0 only.
REQ-035 Starvation check: req1 single read of addr 3 while req0 continuous, RR built -> done1 within 8 cycles.
REQ-036 Async reset during ISSUE of write to addr 7 value 8'h3C -> outputs zero before next edge, no done, memory addr 7 unchanged.
REQ-037 req1 dropped during CAPTURE -> done1 still pulses once, then IDLE with gnt1=0.
REQ-038 Write (wdata 8'h11) then read of unwritten-by-test addr -> rdata unchanged during write done, updated on read done.
